// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit writing a 64-bit result into HI/LO.
// Optional macro MULTDIV_DIVZERO_FLAG_EN adds a fast DivZero completion path.
module mult_div_unit #(
  parameter int WIDTH    = 32,
  parameter int CNT_BITS = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
`ifdef MULTDIV_DIVZERO_FLAG_EN
  ,
  output logic             DivZero
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t                state;
  logic [CNT_BITS-1:0]   cnt;
  logic                  fin_ph;
  logic                  is_div;
  logic                  neg_q;
  logic                  neg_r;
  logic                  dz;
  logic [WIDTH-1:0]      a_raw;
  logic [WIDTH-1:0]      mcand;
  logic [2*WIDTH-1:0]    acc;
  logic [2*WIDTH-1:0]    res_p2;

  logic signed [WIDTH-1:0] opa_s;
  logic signed [WIDTH-1:0] opb_s;
  logic                  sa;
  logic                  sb;
  logic                  b_zero;
  logic [WIDTH:0]        add_sum;
  logic [WIDTH:0]        trial;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic sgn);
    return sgn ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic sgn);
    return sgn ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  always_comb begin
    opa_s   = OperandA;
    opb_s   = OperandB;
    sa      = ~Op[0] & (opa_s < 0);
    sb      = ~Op[0] & (opb_s < 0);
    b_zero  = (OperandB == '0);
    // Multiply: upper half accumulates, multiplier bits shift out of the bottom.
    add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    // Divide: upper half is the partial remainder, lower half dividend/quotient.
    trial   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, mcand};
  end

  // Datapath: magnitudes, iteration, sign correction (no reset needed)
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (Start) begin
          a_raw <= OperandA;
          if (Op[1]) begin
            acc   <= {{WIDTH{1'b0}}, neg_w(OperandA, sa)};
            mcand <= neg_w(OperandB, sb);
          end else begin
            acc   <= {{WIDTH{1'b0}}, neg_w(OperandB, sb)};
            mcand <= neg_w(OperandA, sa);
          end
        end
      end
      RUN: begin
        if (is_div)
          acc <= trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                              : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
          acc <= {add_sum, acc[WIDTH-1:1]};
      end
      FINISH: begin
        if (!fin_ph) begin
          if (dz)
            res_p2 <= {a_raw, {WIDTH{1'b1}}};
          else if (is_div)
            res_p2 <= {neg_w(acc[2*WIDTH-1:WIDTH], neg_r), neg_w(acc[WIDTH-1:0], neg_q)};
          else
            res_p2 <= neg_2w(acc, neg_q);
        end
      end
      default: ;
    endcase
  end

  // Control and architectural HI/LO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      fin_ph <= 1'b0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      Hi     <= '0;
      Lo     <= '0;
`ifdef MULTDIV_DIVZERO_FLAG_EN
      DivZero <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
`ifdef MULTDIV_DIVZERO_FLAG_EN
      DivZero <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (Start) begin
            state  <= RUN;
            cnt    <= '0;
            fin_ph <= 1'b0;
            Busy   <= 1'b1;
            is_div <= Op[1];
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            dz     <= Op[1] & b_zero;
`ifdef MULTDIV_DIVZERO_FLAG_EN
            if (Op[1] && b_zero)
              state <= FINISH;
`endif
          end
        end
        RUN: begin
          cnt <= cnt + CNT_BITS'(1);
          if (cnt == CNT_BITS'(WIDTH - 1))
            state <= FINISH;
        end
        FINISH: begin
          if (!fin_ph) begin
            fin_ph <= 1'b1;
          end else begin
            state <= IDLE;
            Busy  <= 1'b0;
            Done  <= 1'b1;
`ifdef MULTDIV_DIVZERO_FLAG_EN
            if (dz) begin
              DivZero <= 1'b1;
            end else begin
              Hi <= res_p2[2*WIDTH-1:WIDTH];
              Lo <= res_p2[WIDTH-1:0];
            end
`else
            Hi <= res_p2[2*WIDTH-1:WIDTH];
            Lo <= res_p2[WIDTH-1:0];
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and random checks of mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] OperandA;
  logic [31:0] OperandB;
  logic        Busy;
  logic        Done;
  logic [31:0] Hi;
  logic [31:0] Lo;
`ifdef MULTDIV_DIVZERO_FLAG_EN
  logic        DivZero;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] cur_hi = '0;
  logic [31:0] cur_lo = '0;

  mult_div_unit #(.WIDTH(32), .CNT_BITS(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .Start    (Start),
    .Op       (Op),
    .OperandA (OperandA),
    .OperandB (OperandB),
    .Busy     (Busy),
    .Done     (Done),
    .Hi       (Hi),
    .Lo       (Lo)
`ifdef MULTDIV_DIVZERO_FLAG_EN
    ,
    .DivZero  (DivZero)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on 32-bit operands, result {hi, lo}
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint signed sa_, sb_, q, r;
    logic [63:0] ua, ub, p;
    sa_ = longint'($signed(a));
    sb_ = longint'($signed(b));
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    case (op)
      2'b00: begin p = 64'(sa_ * sb_); return p; end
      2'b01: begin p = ua * ub; return p; end
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa_ / sb_;
        r = sa_ % sb_;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {32'(a % b), 32'(a / b)};
      end
    endcase
  endfunction

  // Starts an op at the current negedge; returns at the negedge in which Done is seen.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int ign_at);
    logic [63:0] exp;
    int lat, exp_lat;
    bit found, fast_dz;
    exp = model(op, a, b);
    fast_dz = 1'b0;
`ifdef MULTDIV_DIVZERO_FLAG_EN
    fast_dz = op[1] && (b == 0);
`endif
    exp_lat = fast_dz ? 2 : 34;
    if (fast_dz) exp = {cur_hi, cur_lo};
    Start = 1'b1; Op = op; OperandA = a; OperandB = b;
    @(posedge clk); #1;
    Start = 1'b0; Op = 2'($urandom); OperandA = $urandom; OperandB = $urandom;
    check({tag, ".busy_after_start"}, 64'(Busy), 64'(1));
    lat = 0; found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      @(posedge clk); #1;
      Start = 1'b0;
      lat++;
      @(negedge clk);
      if (Done) found = 1'b1;
      else if (lat == ign_at) begin
        Start = 1'b1; Op = 2'($urandom); OperandA = $urandom; OperandB = $urandom;
      end
    end
    if (!found) lat = -1;
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".busy_at_done"}, 64'(Busy), 64'(0));
    check({tag, ".hi"}, 64'(Hi), 64'(exp[63:32]));
    check({tag, ".lo"}, 64'(Lo), 64'(exp[31:0]));
`ifdef MULTDIV_DIVZERO_FLAG_EN
    check({tag, ".divzero"}, 64'(DivZero), 64'(fast_dz));
`endif
    cur_hi = exp[63:32];
    cur_lo = exp[31:0];
  endtask

  initial begin
    int dones;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    rst = 1'b1; Start = 1'b0; Op = 2'b00; OperandA = '0; OperandB = '0;
    repeat (3) @(negedge clk);
    check("rst.busy", 64'(Busy), 64'(0));
    check("rst.done", 64'(Done), 64'(0));
    check("rst.hi",   64'(Hi),   64'(0));
    check("rst.lo",   64'(Lo),   64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Directed cases, each started in the Done cycle of the previous one
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    check("multu_max.hi_const", 64'(Hi), 64'h0000_0000_FFFF_FFFE);
    check("multu_max.lo_const", 64'(Lo), 64'h1);
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5, -1);
    check("mult_neg.hi_const", 64'(Hi), 64'h0000_0000_FFFF_FFFF);
    check("mult_neg.lo_const", 64'(Lo), 64'h0000_0000_FFFF_FFF1);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, -1);
    check("div_neg.lo_const", 64'(Lo), 64'h0000_0000_FFFF_FFFD);
    run_op("divu_b2b", 2'b11, 32'd100, 32'd7, 5);
    check("divu_b2b.lo_const", 64'(Lo), 64'd14);
    check("divu_b2b.hi_const", 64'(Hi), 64'd2);
    repeat (4) @(negedge clk);
    check("hold.hi", 64'(Hi), 64'd2);
    check("hold.lo", 64'(Lo), 64'd14);
    check("hold.busy", 64'(Busy), 64'(0));
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    check("div_ovf.lo_const", 64'(Lo), 64'h0000_0000_8000_0000);
    run_op("divu_zero", 2'b11, 32'h0000_1234, 32'h0, -1);
    run_op("div_zero_neg", 2'b10, 32'hFFFF_FFF0, 32'h0, -1);

    // Asynchronous reset in the middle of a MULT
    @(negedge clk);
    Start = 1'b1; Op = 2'b00; OperandA = 32'd1234; OperandB = 32'd5678;
    @(posedge clk); #1 Start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst.busy", 64'(Busy), 64'(0));
    check("arst.done", 64'(Done), 64'(0));
    check("arst.hi",   64'(Hi),   64'(0));
    check("arst.lo",   64'(Lo),   64'(0));
    @(negedge clk);
    rst = 1'b0;
    cur_hi = '0; cur_lo = '0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (Done) dones++;
    end
    check("arst.no_done", 64'(dones), 64'(0));
    run_op("after_rst", 2'b00, 32'd1234, 32'd5678, -1);

    // Random operations, back-to-back
    for (int k = 0; k < 24; k++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      if (k % 4 == 1) ra = ra >> $urandom_range(0, 31);
      if (k % 4 == 2) rb = rb >> $urandom_range(0, 31);
      run_op($sformatf("rand%0d", k), rop, ra, rb, (k % 3 == 0) ? 7 : -1);
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
